score_tracker: RTL
==================

// Module: score_tracker
// PURPOSE
//  Parametrised successor to the two-digit/three-life stats counter: N-player BCD score and lives keeper
//  running on the system clock (no event-edge clocking). Point additions are handshaked and rippled
//  one BCD digit per cycle. Tracks saturation, bonus lives, a session high score and game over.
//  Feeds the scoreboard video generator through flattened BCD/lives buses.
// PARAMETERS
//  DIGITS      4  BCD digits per score (>=2)
//  PLAYERS     2  player count (>=1); PW = max(1,$clog2(PLAYERS)) is a localparam
//  LIVES_INIT  3  lives loaded on reset/start (<= LIVES_MAX)
//  LIVES_MAX   9  lives ceiling (<= 15)
//  EXTRA_DIGIT 2  carry out of this digit index grants one life (2 = every 1000 pts); < DIGITS-1
// PORTS
//  clk         in   1                  system clock, all state on rising edge
//  reset       in   1                  asynchronous, active-low (asserted when 0)
//  start       in   1                  sync new game: clear scores, reload lives; hiscore kept
//  add_valid   in   1                  request to add add_pts to player add_player
//  add_ready   out  1                  adder idle; transfer when add_valid & add_ready
//  add_player  in   PW                 target player (>= PLAYERS: request accepted, ignored)
//  add_pts     in   4                  binary 0..9 points; values >9 clamp to 9
//  lose_valid  in   1                  one-cycle strobe: decrement lives of lose_player
//  lose_player in   PW                 target player for lose_valid
//  score_bcd   out  PLAYERS*DIGITS*4   player p at [p*DIGITS*4 +: DIGITS*4], digit 0 = LS nibble
//  lives       out  PLAYERS*4          player p at [p*4 +: 4]
//  hiscore_bcd out  DIGITS*4           highest score seen since reset
//  extra_life  out  1                  one-cycle pulse when a bonus life is granted
//  game_over   out  1                  registered: every player has lives == 0
// BEHAVIOUR
//  Reset (async, reset==0): scores=0, hiscore=0, lives=LIVES_INIT each, state IDLE, add_ready=1,
//   extra_life=0, game_over=0.
//  FSM IDLE -> ADD -> CMP -> IDLE. add_ready=1 only in IDLE.
//  Cycle 0: handshake latches player, clamped pts; carry_in = pts; digit index k = 0.
//  ADD, cycles 1..DIGITS: d' = digit[k] + carry; if d' > 9 then digit[k] = d'-10, carry = 1;
//   else digit[k] = d', carry = 0. Each digit is written in its own cycle. Always DIGITS cycles,
//   no early exit.
//  Carry out of digit DIGITS-1: score saturates to all 9s at end of ADD (written in the last ADD cycle).
//  Carry out of digit EXTRA_DIGIT: extra_life pulses in that cycle; lives +1 capped at LIVES_MAX.
//   No grant if that player's lives == 0.
//  CMP, cycle DIGITS+1: if score > hiscore (plain unsigned compare of BCD vector), hiscore <= score.
//  Cycle DIGITS+2: IDLE, add_ready=1. Back-to-back adds are spaced DIGITS+2 cycles apart.
//  lose_valid is independent of the FSM and is honoured in any state. Lives floor at 0.
//  Bonus grant and lose_valid for the same player in the same cycle: lives unchanged.
//  Adds to a player with lives==0 still score. game_over updates the cycle after lives change.
//  start (sync, priority over all): FSM -> IDLE and aborts any in-flight add (no hiscore update).
//   Scores cleared, lives=LIVES_INIT, extra_life=0. Hiscore retained. Takes effect next edge.
//  Async reset mid-ADD: immediate return to reset values; a partial digit ripple is discarded.
// TESTING
//  reset low, release -> score_bcd=0, lives=3/3, hiscore=0, add_ready=1, game_over=0
//  P0 score 0099, add 5 -> 0104 after 4 ADD cycles; hiscore=0104 in CMP; add_ready high at cycle 6
//  P1 score 0995, add 7 -> 1002; extra_life pulse in ADD cycle 3; P1 lives 3->4
//  P0 score 9995, add 9 -> saturates 9999; hiscore 9999; lives unchanged (lives 9 cap test: 9 stays 9)
//  lose_valid x3 for each player -> lives reach 0, game_over=1 next cycle; 4th lose keeps 0
//  start asserted during ADD of P0 -> scores 0, lives 3, FSM IDLE next cycle, hiscore unchanged

Source files
------------

// File: rtl/score_tracker.sv
// N-player BCD score and lives keeper.
// Point additions ripple through the score one BCD digit per clock, then a
// compare cycle updates the session high score. Lives are adjusted
// independently by lose strobes and by bonus grants from the ripple.
module score_tracker #(
  parameter  int DIGITS      = 4,
  parameter  int PLAYERS     = 2,
  parameter  int LIVES_INIT  = 3,
  parameter  int LIVES_MAX   = 9,
  parameter  int EXTRA_DIGIT = 2,
  localparam int PW          = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          add_valid,
  output logic                          add_ready,
  input  logic [PW-1:0]                 add_player,
  input  logic [3:0]                    add_pts,
  input  logic                          lose_valid,
  input  logic [PW-1:0]                 lose_player,
  output logic [PLAYERS*DIGITS*4-1:0]   score_bcd,
  output logic [PLAYERS*4-1:0]          lives,
  output logic [DIGITS*4-1:0]           hiscore_bcd,
  output logic                          extra_life,
  output logic                          game_over
);

  localparam int SW = DIGITS * 4;
  localparam int KW = $clog2(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_CMP  = 2'd2
  } state_t;

  state_t        state_r;
  logic          add_ready_r;
  logic [PW-1:0] player_r;
  logic          player_ok_r;
  logic [3:0]    carry_r;
  logic [KW-1:0] k_r;
  logic [SW-1:0] score_r [PLAYERS];
  logic [3:0]    lives_r [PLAYERS];
  logic [SW-1:0] hiscore_r;
  logic          extra_life_r;
  logic          game_over_r;

  logic [SW-1:0] sel_score_s;
  logic [3:0]    sel_lives_s;
  logic [3:0]    digit_s;
  logic [4:0]    sum_s;
  logic          carry_out_s;
  logic [3:0]    new_digit_s;
  logic          last_s;
  logic          grant_s;
  logic [3:0]    pts_clamp_s;
  logic          in_range_s;
  logic          all_out_s;

  // Select the target player's score/lives and compute one ripple step.
  always_comb begin
    sel_score_s = '0;
    sel_lives_s = 4'd0;
    for (int p = 0; p < PLAYERS; p++) begin
      if (player_r == PW'(p)) begin
        sel_score_s = score_r[p];
        sel_lives_s = lives_r[p];
      end else begin
        // keep the earlier selection
      end
    end
    digit_s     = sel_score_s[int'(k_r)*4 +: 4];
    sum_s       = 5'(digit_s) + 5'(carry_r);
    carry_out_s = (sum_s > 5'd9);
    if (carry_out_s) begin
      new_digit_s = 4'(sum_s - 5'd10);
    end else begin
      new_digit_s = sum_s[3:0];
    end
    last_s  = (k_r == KW'(DIGITS - 1));
    grant_s = (state_r == S_ADD) && player_ok_r && (k_r == KW'(EXTRA_DIGIT)) &&
              carry_out_s && (sel_lives_s != 4'd0);
  end

  // Request-side decode: clamp points, range-check player, detect all-out.
  always_comb begin
    if (add_pts > 4'd9) begin
      pts_clamp_s = 4'd9;
    end else begin
      pts_clamp_s = add_pts;
    end
    in_range_s = ({1'b0, add_player} < (PW + 1)'(PLAYERS));
    all_out_s  = 1'b1;
    for (int p = 0; p < PLAYERS; p++) begin
      if (lives_r[p] != 4'd0) begin
        all_out_s = 1'b0;
      end else begin
        // player already out; leaves the flag as is
      end
    end
  end

  // Adder FSM: accept request, ripple digits, compare against high score.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      add_ready_r <= 1'b1;
      player_r    <= '0;
      player_ok_r <= 1'b0;
      carry_r     <= 4'd0;
      k_r         <= '0;
      hiscore_r   <= '0;
      for (int p = 0; p < PLAYERS; p++) score_r[p] <= '0;
    end else if (start) begin
      state_r     <= S_IDLE;
      add_ready_r <= 1'b1;
      carry_r     <= 4'd0;
      k_r         <= '0;
      for (int p = 0; p < PLAYERS; p++) score_r[p] <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (add_valid) begin
            player_r    <= add_player;
            player_ok_r <= in_range_s;
            carry_r     <= pts_clamp_s;
            k_r         <= '0;
            state_r     <= S_ADD;
            add_ready_r <= 1'b0;
          end
        end
        S_ADD: begin
          for (int p = 0; p < PLAYERS; p++) begin
            if (player_ok_r && (player_r == PW'(p))) begin
              score_r[p][int'(k_r)*4 +: 4] <= new_digit_s;
              // overflow out of the top digit pins the score at all nines
              if (last_s && carry_out_s) score_r[p] <= {DIGITS{4'd9}};
            end
          end
          carry_r <= {3'd0, carry_out_s};
          if (last_s) begin
            k_r     <= '0;
            state_r <= S_CMP;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        S_CMP: begin
          if (player_ok_r && (sel_score_s > hiscore_r)) hiscore_r <= sel_score_s;
          state_r     <= S_IDLE;
          add_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= S_IDLE;
          add_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Lives: lose strobes and bonus grants; a simultaneous pair cancels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < PLAYERS; p++) lives_r[p] <= 4'(LIVES_INIT);
    end else if (start) begin
      for (int p = 0; p < PLAYERS; p++) lives_r[p] <= 4'(LIVES_INIT);
    end else begin
      for (int p = 0; p < PLAYERS; p++) begin
        if (grant_s && (player_r == PW'(p)) && lose_valid && (lose_player == PW'(p))) begin
          lives_r[p] <= lives_r[p];
        end else if (grant_s && (player_r == PW'(p))) begin
          if (lives_r[p] < 4'(LIVES_MAX)) lives_r[p] <= lives_r[p] + 4'd1;
        end else if (lose_valid && (lose_player == PW'(p))) begin
          if (lives_r[p] != 4'd0) lives_r[p] <= lives_r[p] - 4'd1;
        end
      end
    end
  end

  // Status flags: bonus pulse and game-over, one cycle behind the lives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      extra_life_r <= 1'b0;
      game_over_r  <= 1'b0;
    end else begin
      extra_life_r <= grant_s && !start;
      game_over_r  <= all_out_s;
    end
  end

  // Flatten per-player registers onto the scoreboard buses.
  always_comb begin
    score_bcd = '0;
    lives     = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      score_bcd[p*SW +: SW] = score_r[p];
      lives[p*4 +: 4]       = lives_r[p];
    end
  end

  assign add_ready   = add_ready_r;
  assign hiscore_bcd = hiscore_r;
  assign extra_life  = extra_life_r;
  assign game_over   = game_over_r;

endmodule
